// File: rtl/vga_pixel_feeder_if.sv
// Byte-stream handshake into the VGA pixel feeder.
// The source drives in_data/in_valid. The feeder answers with in_ready.
interface vga_pixel_feeder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/vga_pixel_feeder.sv
// Packs byte pairs into 12-bit RGB codes and strobes them into the VGA framebuffer with shaped addInput pulses.
// Optional malformed-pair rejection and counting is compiled in with `define BYTE_CHECK_EN.
module vga_pixel_feeder #(
  parameter int PW       = 40,
  parameter int PH       = 30,
  parameter int PULSE_HI = 2,
  parameter int PULSE_LO = 2,
  parameter int CLR_LEN  = 2
) (
  input  logic                clk_50,
  input  logic                reset_n,
  vga_pixel_feeder_if.slave   stream,
  input  logic                frame_sync,
  output logic                addInput,
  output logic [11:0]         rgbCode,
  output logic                map_reset,
  output logic [10:0]         pix_index,
  output logic                frame_done,
  output logic [7:0]          err_cnt
);

  localparam int NPIX  = PW * PH;
  localparam int CMAX0 = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
  localparam int CMAX  = (CMAX0 > CLR_LEN) ? CMAX0 : CLR_LEN;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0] HI_LAST  = CW'(PULSE_HI - 1);
  localparam logic [CW-1:0] LO_LAST  = CW'(PULSE_LO - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_LEN - 1);
  localparam logic [10:0]   LAST_PIX = 11'(NPIX - 1);

  if (PULSE_HI < 1 || PULSE_LO < 1 || CLR_LEN < 1) begin : g_bad_param
    $error("vga_pixel_feeder: PULSE_HI, PULSE_LO and CLR_LEN must be >= 1");
  end
  if (NPIX > 2048) begin : g_bad_size
    $error("vga_pixel_feeder: PW*PH does not fit the 11-bit pixel index");
  end

  typedef enum logic [2:0] {S_B0, S_B1, S_HI, S_LO, S_CLR} state_t;

  state_t        state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [7:0]    rg_q,     rg_d;
  logic [11:0]   rgb_q,    rgb_d;
  logic          add_q,    add_d;
  logic          mrst_q,   mrst_d;
  logic [10:0]   pix_q,    pix_d;
  logic          fdone_q,  fdone_d;
  logic          rdy_en_q, rdy_en_d;
  logic [7:0]    err_q,    err_d;

  logic in_ready_w;
  logic accept;
  logic drop;

  // rdy_en_q keeps in_ready low during reset and for the first edge after release.
  assign in_ready_w = rdy_en_q && !frame_sync && (state_q == S_B0 || state_q == S_B1);
  assign accept     = in_ready_w && stream.in_valid;

`ifdef BYTE_CHECK_EN
  assign drop = |stream.in_data[7:4];
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rg_d     = rg_q;
    rgb_d    = rgb_q;
    add_d    = add_q;
    mrst_d   = mrst_q;
    pix_d    = pix_q;
    fdone_d  = 1'b0;
    rdy_en_d = 1'b1;
    err_d    = err_q;

    if (frame_sync) begin
      // Sync overrides everything. A held sync keeps restarting the clear window.
      state_d = S_CLR;
      cnt_d   = '0;
      add_d   = 1'b0;
      pix_d   = '0;
      mrst_d  = 1'b1;
    end else begin
      case (state_q)
        S_B0: begin
          if (accept) begin
            rg_d    = stream.in_data;
            state_d = S_B1;
          end
        end
        S_B1: begin
          if (accept) begin
            if (drop) begin
              state_d = S_B0;
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end else begin
              rgb_d   = {rg_q, stream.in_data[3:0]};
              add_d   = 1'b1;
              cnt_d   = '0;
              state_d = S_HI;
            end
          end
        end
        S_HI: begin
          if (cnt_q == HI_LAST) begin
            add_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_LO;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_LO: begin
          if (cnt_q == LO_LAST) begin
            cnt_d   = '0;
            state_d = S_B0;
            if (pix_q == LAST_PIX) begin
              pix_d   = '0;
              fdone_d = 1'b1;
            end else begin
              pix_d = pix_q + 11'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CLR: begin
          if (cnt_q == CLR_LAST) begin
            mrst_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_B0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_B0;
          cnt_d   = '0;
          add_d   = 1'b0;
          mrst_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_B0;
      cnt_q    <= '0;
      rg_q     <= '0;
      rgb_q    <= '0;
      add_q    <= 1'b0;
      mrst_q   <= 1'b0;
      pix_q    <= '0;
      fdone_q  <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rg_q     <= rg_d;
      rgb_q    <= rgb_d;
      add_q    <= add_d;
      mrst_q   <= mrst_d;
      pix_q    <= pix_d;
      fdone_q  <= fdone_d;
      rdy_en_q <= rdy_en_d;
    end
  end

`ifdef BYTE_CHECK_EN
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) err_q <= '0;
    else          err_q <= err_d;
  end
`else
  assign err_q = '0;
`endif

  assign stream.in_ready = in_ready_w;
  assign addInput        = add_q;
  assign rgbCode         = rgb_q;
  assign map_reset       = mrst_q;
  assign pix_index       = pix_q;
  assign frame_done      = fdone_q;
  assign err_cnt         = err_q;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Self-checking bench for vga_pixel_feeder: a cycle-count model of pixel timing checked every cycle, plus literal checks.
module tb_vga_pixel_feeder;
  localparam int PW = 40, PH = 30, PHI = 2, PLO = 2, CLR = 2, NPIX = PW * PH;
`ifdef BYTE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_sync = 1'b0;
  logic        addInput, map_reset, frame_done;
  logic [11:0] rgbCode;
  logic [10:0] pix_index;
  logic [7:0]  err_cnt;

  vga_pixel_feeder_if bus ();

  vga_pixel_feeder #(.PW(PW), .PH(PH), .PULSE_HI(PHI), .PULSE_LO(PLO), .CLR_LEN(CLR)) u_dut (
    .clk_50(clk_50), .reset_n(reset_n), .stream(bus), .frame_sync(frame_sync),
    .addInput(addInput), .rgbCode(rgbCode), .map_reset(map_reset),
    .pix_index(pix_index), .frame_done(frame_done), .err_cnt(err_cnt)
  );

  always #5 clk_50 = ~clk_50;

  // Model state: busy/clr are remaining cycles of the pixel window / clear window.
  int         m_rdy, m_have, m_busy, m_clr, m_pix, m_err, m_fd;
  logic [7:0] m_rg;
  logic [11:0] m_rgb;

  always @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      m_rdy <= 0; m_have <= 0; m_busy <= 0; m_clr <= 0; m_pix <= 0; m_err <= 0; m_fd <= 0;
      m_rg <= '0; m_rgb <= '0;
    end else begin
      m_fd  <= 0;
      m_rdy <= 1;
      if (frame_sync) begin
        m_have <= 0; m_busy <= 0; m_clr <= CLR; m_pix <= 0;
      end else if (m_clr > 0) begin
        m_clr <= m_clr - 1;
      end else if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          if (m_pix == NPIX - 1) begin m_pix <= 0; m_fd <= 1; end
          else m_pix <= m_pix + 1;
        end
      end else if (m_rdy != 0 && bus.in_valid) begin
        if (m_have == 0) begin
          m_rg <= bus.in_data; m_have <= 1;
        end else begin
          m_have <= 0;
          if (CHK && bus.in_data[7:4] != 4'h0) m_err <= (m_err < 255) ? m_err + 1 : 255;
          else begin m_rgb <= {m_rg, bus.in_data[3:0]}; m_busy <= PHI + PLO; end
        end
      end
    end
  end

  int n_chk = 0, n_err = 0;
  int pulses = 0, fd_cnt = 0;
  logic prev_add = 1'b0;
  logic s_add, s_rdy, s_map, s_fd;
  logic [11:0] s_rgb;
  logic [10:0] s_pix;
  logic [7:0]  s_err;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // One cycle: sample and compare against the model at negedge, then step to just after the next posedge.
  task automatic tick();
    int exp_rdy;
    @(negedge clk_50);
    s_add = addInput; s_rdy = bus.in_ready; s_map = map_reset; s_fd = frame_done;
    s_rgb = rgbCode; s_pix = pix_index; s_err = err_cnt;
    exp_rdy = (m_rdy != 0 && m_busy == 0 && m_clr == 0 && !frame_sync) ? 1 : 0;
    chk("in_ready", int'(s_rdy), exp_rdy);
    chk("addInput", int'(s_add), (m_busy > PLO) ? 1 : 0);
    chk("map_reset", int'(s_map), (m_clr > 0) ? 1 : 0);
    chk("rgbCode", int'(s_rgb), int'(m_rgb));
    chk("pix_index", int'(s_pix), m_pix);
    chk("frame_done", int'(s_fd), m_fd);
    chk("err_cnt", int'(s_err), m_err);
    if (s_add && !prev_add) pulses++;
    prev_add = s_add;
    if (s_fd) fd_cnt++;
    @(posedge clk_50); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (s_rdy) begin acc = 1'b1; break; end
    end
    bus.in_valid = 1'b0;
    chk("byte_accepted", int'(acc), 1);
  endtask

  task automatic sync_pulse();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  initial begin
    logic [4:0] add_pat, rdy_pat, map_pat;
    int base_p, base_f;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state
    ticks(2);
    chk("rst_in_ready", int'(s_rdy), 0);
    chk("rst_addInput", int'(s_add), 0);
    chk("rst_pix", int'(s_pix), 0);
    @(posedge clk_50); #1;
    reset_n = 1'b1;
    ticks(2);
    chk("post_rst_ready", int'(s_rdy), 1);

    // 0xA5,0x03 -> 0xA53, addInput 1,1,0,0 while in_ready low 4 cycles
    base_p = pulses;
    send(8'hA5);
    send(8'h03);
    add_pat = 5'b00011;
    rdy_pat = 5'b10000;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_add_shape", int'(s_add), int'(add_pat[k]));
      chk("t2_ready_shape", int'(s_rdy), int'(rdy_pat[k]));
    end
    chk("t2_rgb", int'(s_rgb), 'hA53);
    chk("t2_pix", int'(s_pix), 1);
    chk("t2_pulses", pulses - base_p, 1);

    // Asynchronous reset mid-pulse clears outputs without a clock edge
    send(8'h11);
    send(8'h02);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_add", int'(addInput), 0);
    chk("arst_rgb", int'(rgbCode), 0);
    chk("arst_map", int'(map_reset), 0);
    chk("arst_pix", int'(pix_index), 0);
    chk("arst_fd", int'(frame_done), 0);
    chk("arst_err", int'(err_cnt), 0);
    chk("arst_ready", int'(bus.in_ready), 0);
    tick();
    reset_n = 1'b1;
    ticks(2);
    chk("rel_ready", int'(s_rdy), 1);
    chk("rel_pix", int'(s_pix), 0);

    // Byte0 then sync: partial pair discarded, map_reset 2 cycles
    send(8'h12);
    sync_pulse();
    map_pat = 5'b00011;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_map_reset", int'(s_map), int'(map_pat[k]));
    end
    send(8'h34);
    send(8'h05);
    ticks(5);
    chk("t4_rgb", int'(s_rgb), 'h345);
    chk("t4_pix", int'(s_pix), 1);

    // Malformed pair
    base_p = pulses;
    send(8'hFF);
    send(8'h13);
    ticks(5);
    if (CHK) begin
      chk("t5_err", int'(s_err), 1);
      chk("t5_no_pulse", pulses - base_p, 0);
      chk("t5_pix", int'(s_pix), 1);
    end else begin
      chk("t5_rgb", int'(s_rgb), 'hFF3);
      chk("t5_pulse", pulses - base_p, 1);
      chk("t5_err0", int'(s_err), 0);
    end

    // Sync while addInput is high
    send(8'h6C);
    send(8'h07);
    base_f = fd_cnt;
    sync_pulse();
    chk("t6_add_before", int'(s_add), 1);
    tick();
    chk("t6_add_cut", int'(s_add), 0);
    chk("t6_pix", int'(s_pix), 0);
    chk("t6_map", int'(s_map), 1);
    ticks(3);
    chk("t6_no_fd", fd_cnt - base_f, 0);

    // Full frame: 1200 pairs wrap the index once
    sync_pulse();
    ticks(3);
    base_p = pulses;
    base_f = fd_cnt;
    for (int n = 0; n < NPIX; n++) begin
      send(8'($urandom_range(0, 255)));
      send({4'h0, 4'($urandom_range(0, 15))});
    end
    ticks(5);
    chk("t3_pulses", pulses - base_p, NPIX);
    chk("t3_frame_done", fd_cnt - base_f, 1);
    chk("t3_pix_wrap", int'(s_pix), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
